// File: rtl/smart_parking_system.sv
// Car-park occupancy controller: edge-detects entry/exit sensors, keeps the occupied count,
// pulses the gate for each accepted event and drives a 3-digit 7-segment free-space display.
module smart_parking_system #(
    parameter int CAPACITY = 100,
    parameter int CNT_W    = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Car_Enter,
    input  logic       Car_Exit,
    output logic       Gate_Open,
    output logic [6:0] seg0,
    output logic [6:0] seg1,
    output logic [6:0] seg2
);

    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    logic             r_enter_d;
    logic             r_exit_d;
    logic             r_armed;
    logic [CNT_W-1:0] r_occupied;
    logic             r_gate;

    logic             w_enter_evt;
    logic             w_exit_evt;
    logic [CNT_W-1:0] w_occ_nxt;
    logic             w_gate_nxt;
    logic [CNT_W-1:0] w_free;
    logic [3:0]       w_hund;
    logic [3:0]       w_tens;
    logic [3:0]       w_ones;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    seg_encode = 7'b0111111;
            4'd1:    seg_encode = 7'b0000110;
            4'd2:    seg_encode = 7'b1011011;
            4'd3:    seg_encode = 7'b1001111;
            4'd4:    seg_encode = 7'b1100110;
            4'd5:    seg_encode = 7'b1101101;
            4'd6:    seg_encode = 7'b1111101;
            4'd7:    seg_encode = 7'b0000111;
            4'd8:    seg_encode = 7'b1111111;
            4'd9:    seg_encode = 7'b1101111;
            default: seg_encode = 7'b0000000;
        endcase
    endfunction

    // r_armed masks the first clock after reset so an input already high is not seen as an edge
    assign w_enter_evt = r_armed & Car_Enter & ~r_enter_d;
    assign w_exit_evt  = r_armed & Car_Exit  & ~r_exit_d;

    always_comb begin
        w_occ_nxt  = r_occupied;
        w_gate_nxt = 1'b0;
        case ({w_enter_evt, w_exit_evt})
            2'b11: w_gate_nxt = 1'b1;
            2'b10: begin
                if (r_occupied < CAP) begin
                    w_occ_nxt  = r_occupied + CNT_W'(1);
                    w_gate_nxt = 1'b1;
                end
            end
            2'b01: begin
                if (r_occupied != '0) begin
                    w_occ_nxt  = r_occupied - CNT_W'(1);
                    w_gate_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_enter_d  <= 1'b0;
            r_exit_d   <= 1'b0;
            r_armed    <= 1'b0;
            r_occupied <= '0;
            r_gate     <= 1'b0;
        end else begin
            r_enter_d  <= Car_Enter;
            r_exit_d   <= Car_Exit;
            r_armed    <= 1'b1;
            r_occupied <= w_occ_nxt;
            r_gate     <= w_gate_nxt;
        end
    end

    assign w_free = CAP - r_occupied;
    assign w_hund = 4'(w_free / CNT_W'(100));
    assign w_tens = 4'((w_free / CNT_W'(10)) % CNT_W'(10));
    assign w_ones = 4'(w_free % CNT_W'(10));

    assign Gate_Open = r_gate;
    assign seg2      = seg_encode(w_hund);
    assign seg1      = seg_encode(w_tens);
    assign seg0      = seg_encode(w_ones);

endmodule

// File: tb/tb_smart_parking_system.sv
// Directed bench for smart_parking_system: stimulus pushes the expected display for each
// gate pulse into a queue; a negedge monitor pops and compares whenever Gate_Open is high.
module tb_smart_parking_system;

    logic       CLK;
    logic       RST;
    logic       Car_Enter;
    logic       Car_Exit;
    logic       Gate_Open;
    logic [6:0] seg0;
    logic [6:0] seg1;
    logic [6:0] seg2;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;
    int occ      = 0;

    logic [20:0] exp_q[$];

    localparam logic [20:0] D100 = 21'b0000110_0111111_0111111;
    localparam logic [20:0] D000 = 21'b0111111_0111111_0111111;
    localparam logic [20:0] D010 = 21'b0111111_0000110_0111111;
    localparam logic [20:0] D008 = 21'b0111111_0111111_1111111;
    localparam logic [20:0] D007 = 21'b0111111_0111111_0000111;

    smart_parking_system #(.CAPACITY(100), .CNT_W(10)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Car_Enter (Car_Enter),
        .Car_Exit  (Car_Exit),
        .Gate_Open (Gate_Open),
        .seg0      (seg0),
        .seg1      (seg1),
        .seg2      (seg2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
        return tbl[d];
    endfunction

    function automatic logic [20:0] disp_of(input int occupied);
        int f;
        f = 100 - occupied;
        return {seg_of(f / 100), seg_of((f / 10) % 10), seg_of(f % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    // Single-cycle event; the bench's own occupancy model decides whether a pulse is due
    task automatic ev(input logic en, input logic ex);
        bit acc;
        @(posedge CLK); #1;
        Car_Enter = en;
        Car_Exit  = ex;
        acc = 1'b0;
        if (en && ex) acc = 1'b1;
        else if (en && occ < 100) begin occ++; acc = 1'b1; end
        else if (ex && occ > 0) begin occ--; acc = 1'b1; end
        if (acc) exp_q.push_back(disp_of(occ));
        @(posedge CLK); #1;
        Car_Enter = 1'b0;
        Car_Exit  = 1'b0;
        @(posedge CLK); #1;
    endtask

    always @(negedge CLK) begin
        if (RST && Gate_Open) begin
            n_pulses++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL gate_pulse: unexpected Gate_Open=1 with display %b", {seg2, seg1, seg0});
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                if ({seg2, seg1, seg0} !== e) begin
                    n_fail++;
                    $display("FAIL pulse_display: got %b, expected %b", {seg2, seg1, seg0}, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        RST = 1'b0; Car_Enter = 1'b0; Car_Exit = 1'b0;
        @(negedge CLK);
        chk("reset_gate", 32'(Gate_Open), 32'd0);
        chk("reset_display", 32'({seg2, seg1, seg0}), 32'(D100));
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        chk("post_reset_display", 32'({seg2, seg1, seg0}), 32'(D100));

        p0 = n_pulses;
        for (int i = 0; i < 100; i++) ev(1'b1, 1'b0);
        chk("fill_pulses", 32'(n_pulses - p0), 32'd100);
        chk("full_display", 32'({seg2, seg1, seg0}), 32'(D000));

        p0 = n_pulses;
        for (int i = 0; i < 3; i++) ev(1'b1, 1'b0);
        chk("full_reject_pulses", 32'(n_pulses - p0), 32'd0);
        chk("full_reject_display", 32'({seg2, seg1, seg0}), 32'(D000));

        p0 = n_pulses;
        for (int i = 0; i < 10; i++) ev(1'b0, 1'b1);
        chk("exit_pulses", 32'(n_pulses - p0), 32'd10);
        chk("exit_display", 32'({seg2, seg1, seg0}), 32'(D010));

        p0 = n_pulses;
        for (int i = 0; i < 2; i++) ev(1'b1, 1'b0);
        chk("reentry_pulses", 32'(n_pulses - p0), 32'd2);
        chk("reentry_display", 32'({seg2, seg1, seg0}), 32'(D008));

        // Enter held for 5 cycles must count once
        p0 = n_pulses;
        @(posedge CLK); #1;
        Car_Enter = 1'b1;
        occ++;
        exp_q.push_back(disp_of(occ));
        repeat (5) @(posedge CLK);
        #1 Car_Enter = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("held_pulses", 32'(n_pulses - p0), 32'd1);
        chk("held_display", 32'({seg2, seg1, seg0}), 32'(D007));

        p0 = n_pulses;
        ev(1'b1, 1'b1);
        chk("simul_pulses", 32'(n_pulses - p0), 32'd1);
        chk("simul_display", 32'({seg2, seg1, seg0}), 32'(D007));

        // Reset asserted mid-cycle while a gate pulse is high; entry still held at release
        @(posedge CLK); #1;
        Car_Enter = 1'b1;
        @(posedge CLK); #1;
        chk("pre_reset_gate", 32'(Gate_Open), 32'd1);
        #1 RST = 1'b0;
        #1;
        chk("async_reset_gate", 32'(Gate_Open), 32'd0);
        chk("async_reset_display", 32'({seg2, seg1, seg0}), 32'(D100));
        occ = 0;
        #1 RST = 1'b1;
        p0 = n_pulses;
        repeat (3) @(posedge CLK);
        #1 Car_Enter = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("held_at_release_pulses", 32'(n_pulses - p0), 32'd0);
        chk("held_at_release_display", 32'({seg2, seg1, seg0}), 32'(D100));

        p0 = n_pulses;
        ev(1'b0, 1'b1);
        chk("empty_exit_pulses", 32'(n_pulses - p0), 32'd0);
        chk("empty_exit_display", 32'({seg2, seg1, seg0}), 32'(D100));

        p0 = n_pulses;
        ev(1'b1, 1'b1);
        chk("empty_simul_pulses", 32'(n_pulses - p0), 32'd1);
        chk("empty_simul_display", 32'({seg2, seg1, seg0}), 32'(D100));

        repeat (3) @(posedge CLK);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/smart_parking_system.md
Name:
smart_parking_system

Overview:
- Parking-lot occupancy controller for a single car park.
- Counts cars entering and leaving, and pulses a gate-open output for each accepted entry or exit.
- Drives three 7-segment digits showing the number of free spaces (hundreds, tens, ones).
- Sits between the entry/exit sensors and the gate actuator and display board.

Parameters:
- CAPACITY, 100, total parking spaces; legal range 1..999.
- CNT_W, 10, width of the occupancy and free-space counters; must hold CAPACITY.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  reset; asynchronous, active-low.
- Car_Enter  input  1  entry sensor; a car is requesting entry when this goes high.
- Car_Exit  input  1  exit sensor; a car is leaving when this goes high.
- Gate_Open  output  1  one-cycle pulse opening the gate.
- seg0  output  7  ones digit of free spaces.
- seg1  output  7  tens digit of free spaces.
- seg2  output  7  hundreds digit of free spaces.

Behaviour:
- Reset (RST=0, asynchronous):
  - occupied=0, Gate_Open=0, edge-detect registers=0.
  - Display shows CAPACITY; with default 100: seg2=0000110, seg1=0111111, seg0=0111111.
- Event detection:
  - Car_Enter and Car_Exit are rising-edge detected against a registered copy of each input.
  - One event per 0->1 transition; an input held high counts once.
  - An input already high when reset releases produces no event.
- Entry:
  - Accepted if occupied < CAPACITY: occupied+1 on that clock edge, Gate_Open=1 for the next cycle.
  - Rejected when full: occupied unchanged, Gate_Open stays 0.
- Exit:
  - Accepted if occupied > 0: occupied-1, Gate_Open=1 for one cycle.
  - Ignored when empty: no underflow, Gate_Open=0.
- Simultaneous entry and exit edges in the same cycle:
  - occupied unchanged, Gate_Open=1 for one cycle.
  - This applies even when full or empty (exit frees the space the entering car takes).
- Gate_Open:
  - Registered; high exactly one cycle per accepted event.
  - Back-to-back events give back-to-back pulses.
- Free spaces:
  - free = CAPACITY - occupied, never negative and never above CAPACITY.
  - Binary-to-BCD conversion: hundreds = free/100, tens = (free/10)%10, ones = free%10.
  - Combinational from the counter register, so the display changes on the same edge as the count.
- Display:
  - Leading zeros are displayed (e.g. 8 shows as 0-0-8).
  - Segment format: bit order {g,f,e,d,c,b,a}, active-high (1 = lit).
  - Digit codes:
    - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
    - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- Reset mid-operation:
  - Immediately clears the count and Gate_Open regardless of the clock.
  - Any pending event is discarded.
- No other outputs. Latency from sampled input edge to count, display and Gate_Open update is one clock.

Test Plan:
- Reset:
  - Stimulus: assert RST=0 for 1 cycle, release.
  - Required: Gate_Open=0; seg2/seg1/seg0 = 0000110/0111111/0111111 (100 free).
- Fill to capacity:
  - Stimulus: 100 single-cycle Car_Enter pulses separated by idle cycles.
  - Required: Gate_Open pulses 100 times, one cycle each; final display 0-0-0 (all digits 0111111).
- Entry when full:
  - Stimulus: 3 further Car_Enter pulses.
  - Required: Gate_Open stays 0; display remains 0-0-0.
- Exits:
  - Stimulus: 10 Car_Exit pulses.
  - Required: 10 Gate_Open pulses; display 0-1-0 (seg2=0111111, seg1=0000110, seg0=0111111).
- Re-entry:
  - Stimulus: 2 Car_Enter pulses.
  - Required: 2 Gate_Open pulses; display 0-0-8 (seg0=1111111).
- Edge cases:
  - Exit with 100 free: no pulse, display stays 100.
  - Car_Enter held high 5 cycles: counts as exactly one entry.
  - Simultaneous enter+exit edges: count unchanged, one Gate_Open pulse.
  - Async reset asserted between clock edges: outputs return to reset values immediately.
